// File: rtl/rf_stream_loader_if.sv
// Valid/ready word stream feeding the register-file loader.
// S_LAST flags the final word of an X/W matrix pair.
interface rf_stream_loader_if #(
  parameter int DW = 16
);
  logic          S_VALID;
  logic          S_READY;
  logic [DW-1:0] S_DATA;
  logic          S_LAST;

  modport master (
    output S_VALID,
    output S_DATA,
    output S_LAST,
    input  S_READY
  );

  modport slave (
    input  S_VALID,
    input  S_DATA,
    input  S_LAST,
    output S_READY
  );
endinterface

// File: rtl/rf_stream_loader.sv
// Row assembler for the systolic-array register file: 8 X + 8 W
// words per row, 8 rows, then a fixed compute window and DONE.
module rf_stream_loader #(
  parameter  int DW         = 16,
  parameter  int N          = 8,
  parameter  int RUN_CYCLES = 23,
  localparam int IW         = $clog2(N),
  localparam int WW         = $clog2(2*N),
  localparam int RW         = $clog2(RUN_CYCLES)
) (
  input  logic          CLK,
  input  logic          RST,
  rf_stream_loader_if.slave s,
  output logic          RF_EN,
  output logic          WRITE,
  output logic [IW-1:0] IDX,
  output logic [DW-1:0] DATA_OUT_0,
  output logic [DW-1:0] DATA_OUT_1,
  output logic [DW-1:0] DATA_OUT_2,
  output logic [DW-1:0] DATA_OUT_3,
  output logic [DW-1:0] DATA_OUT_4,
  output logic [DW-1:0] DATA_OUT_5,
  output logic [DW-1:0] DATA_OUT_6,
  output logic [DW-1:0] DATA_OUT_7,
  output logic [DW-1:0] DATA_OUT_8,
  output logic [DW-1:0] DATA_OUT_9,
  output logic [DW-1:0] DATA_OUT_A,
  output logic [DW-1:0] DATA_OUT_B,
  output logic [DW-1:0] DATA_OUT_C,
  output logic [DW-1:0] DATA_OUT_D,
  output logic [DW-1:0] DATA_OUT_E,
  output logic [DW-1:0] DATA_OUT_F,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR
);

  typedef enum logic [1:0] {
    FILL,
    WR,
    RUN,
    DN
  } state_t;

  localparam logic [WW-1:0] W_LAST = WW'(2*N-1);
  localparam logic [IW-1:0] R_LAST = IW'(N-1);
  localparam logic [RW-1:0] C_LAST = RW'(RUN_CYCLES-1);

  state_t        state;
  state_t        state_nx;
  logic [WW-1:0] wcnt;
  logic [IW-1:0] rcnt;
  logic [RW-1:0] run_cnt;
  logic [DW-1:0] rbuf [2*N];
  logic          acc;
  logic          row_end;
  logic          last_g;
  logic          bad_last;

  assign acc      = s.S_VALID && (state == FILL);
  assign row_end  = (wcnt == W_LAST);
  assign last_g   = row_end && (rcnt == R_LAST);
  assign bad_last = acc && s.S_LAST && !last_g;

  always_ff @(posedge CLK) begin
    if (RST) state <= FILL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL: if (acc && row_end && !bad_last) state_nx = WR;
      WR:   state_nx = (rcnt == R_LAST) ? RUN : FILL;
      RUN:  if (run_cnt == C_LAST) state_nx = DN;
      DN:   state_nx = FILL;
    endcase
  end

  // An early S_LAST drops the whole matrix; a missing one only flags it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wcnt    <= '0;
      rcnt    <= '0;
      run_cnt <= '0;
      ERR     <= 1'b0;
      for (int i = 0; i < 2*N; i++) rbuf[i] <= '0;
    end else begin
      if (acc) begin
        rbuf[wcnt] <= s.S_DATA;
        if (bad_last) begin
          wcnt <= '0;
          rcnt <= '0;
          ERR  <= 1'b1;
        end else begin
          wcnt <= row_end ? '0 : wcnt + 1'b1;
          if (last_g && !s.S_LAST) ERR <= 1'b1;
        end
      end
      if (state == WR)
        rcnt <= (rcnt == R_LAST) ? '0 : rcnt + 1'b1;
      if (state == RUN)
        run_cnt <= (run_cnt == C_LAST) ? '0 : run_cnt + 1'b1;
    end
  end

  assign s.S_READY = (state == FILL);
  assign RF_EN     = (state == WR) || (state == RUN);
  assign WRITE     = (state == WR);
  assign IDX       = (state == WR) ? rcnt : '0;
  assign BUSY      = (state != FILL);
  assign DONE      = (state == DN);

  assign DATA_OUT_0 = rbuf[0];
  assign DATA_OUT_1 = rbuf[1];
  assign DATA_OUT_2 = rbuf[2];
  assign DATA_OUT_3 = rbuf[3];
  assign DATA_OUT_4 = rbuf[4];
  assign DATA_OUT_5 = rbuf[5];
  assign DATA_OUT_6 = rbuf[6];
  assign DATA_OUT_7 = rbuf[7];
  assign DATA_OUT_8 = rbuf[8];
  assign DATA_OUT_9 = rbuf[9];
  assign DATA_OUT_A = rbuf[10];
  assign DATA_OUT_B = rbuf[11];
  assign DATA_OUT_C = rbuf[12];
  assign DATA_OUT_D = rbuf[13];
  assign DATA_OUT_E = rbuf[14];
  assign DATA_OUT_F = rbuf[15];

endmodule

// File: tb/tb_rf_stream_loader.sv
// Self-checking bench for rf_stream_loader: scenario table,
// row-content reference, and a reset-during-RUN sequence.
module tb_rf_stream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_en;
  logic        write;
  logic [2:0]  idx;
  logic [15:0] dout [16];
  logic        busy;
  logic        done;
  logic        err;

  rf_stream_loader_if #(.DW(16)) sif ();

  always #5 clk = ~clk;

  rf_stream_loader dut (
    .CLK(clk), .RST(rst), .s(sif.slave),
    .RF_EN(rf_en), .WRITE(write), .IDX(idx),
    .DATA_OUT_0(dout[0]),  .DATA_OUT_1(dout[1]),
    .DATA_OUT_2(dout[2]),  .DATA_OUT_3(dout[3]),
    .DATA_OUT_4(dout[4]),  .DATA_OUT_5(dout[5]),
    .DATA_OUT_6(dout[6]),  .DATA_OUT_7(dout[7]),
    .DATA_OUT_8(dout[8]),  .DATA_OUT_9(dout[9]),
    .DATA_OUT_A(dout[10]), .DATA_OUT_B(dout[11]),
    .DATA_OUT_C(dout[12]), .DATA_OUT_D(dout[13]),
    .DATA_OUT_E(dout[14]), .DATA_OUT_F(dout[15]),
    .BUSY(busy), .DONE(done), .ERR(err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pack_row();
    logic [255:0] r;
    for (int j = 0; j < 16; j++) r[16*j +: 16] = dout[j];
    return r;
  endfunction

  // Monitor: observed WR rows, RUN cycles and DONE pulses.
  int           cyc = 0;
  int           run_total = 0;
  int           done_total = 0;
  int           done_cyc = 0;
  logic         prev_done = 1'b0;
  logic         ready_after_done = 1'b0;
  logic [255:0] wr_row_q [$];
  int           wr_idx_q [$];
  int           wr_cyc_q [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_done <= done && !rst;
    if (prev_done) ready_after_done <= sif.S_READY;
    if (!rst) begin
      if (rf_en && write) begin
        wr_row_q.push_back(pack_row());
        wr_idx_q.push_back(int'(idx));
        wr_cyc_q.push_back(cyc);
      end
      if (rf_en && !write) run_total <= run_total + 1;
      if (done) begin
        done_total <= done_total + 1;
        done_cyc   <= cyc;
      end
    end
  end

  logic [15:0] w [128];

  task automatic send(input logic [15:0] d, input logic l, input int gap);
    int t = 0;
    while ($urandom_range(99) < gap) begin
      sif.S_VALID = 1'b0;
      @(negedge clk);
    end
    sif.S_VALID = 1'b1;
    sif.S_DATA  = d;
    sif.S_LAST  = l;
    while (!sif.S_READY && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk_int("ready_timeout", t, 0);
    @(negedge clk);
    sif.S_VALID = 1'b0;
    sif.S_LAST  = 1'b0;
  endtask

  task automatic reset_chk();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_int("rst_ready", int'(sif.S_READY), 1);
    chk_int("rst_rf_en", int'(rf_en), 0);
    chk_int("rst_write", int'(write), 0);
    chk_int("rst_idx",   int'(idx), 0);
    chk_row("rst_data",  pack_row(), '0);
    chk_int("rst_busy",  int'(busy), 0);
    chk_int("rst_done",  int'(done), 0);
    chk_int("rst_err",   int'(err), 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // lastp: 127 = clean frame, <127 = early S_LAST, -1 = never asserted.
  task automatic run_case(input int gap, input int lastp, input bit rnd,
                          input int exp_wr, input bit exp_done,
                          input bit exp_err, input bit timing);
    int wb = wr_row_q.size();
    int rb = run_total;
    int db = done_total;
    int n  = (lastp >= 0 && lastp < 127) ? lastp + 1 : 128;
    int t  = 0;
    int nw;
    logic [255:0] er;
    for (int k = 0; k < n; k++)
      w[k] = rnd ? 16'($urandom) : 16'(16'h0100 + k);
    for (int k = 0; k < n; k++)
      send(w[k], k == lastp, gap);
    if (exp_done) begin
      while (done_total == db && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) chk_int("done_timeout", t, 0);
      repeat (3) @(negedge clk);
    end else begin
      repeat (40) @(negedge clk);
    end
    nw = wr_row_q.size() - wb;
    chk_int("wr_count", nw, exp_wr);
    for (int i = 0; i < nw && i < 8; i++) begin
      for (int j = 0; j < 16; j++) er[16*j +: 16] = w[16*i + j];
      chk_int($sformatf("wr%0d_idx", i), wr_idx_q[wb+i], i);
      chk_row($sformatf("wr%0d_data", i), wr_row_q[wb+i], er);
    end
    chk_int("done_count", done_total - db, int'(exp_done));
    chk_int("run_cycles", run_total - rb, exp_done ? 23 : 0);
    chk_int("err", int'(err), int'(exp_err));
    if (exp_done)
      chk_int("ready_after_done", int'(ready_after_done), 1);
    if (timing && nw == 8) begin
      t = 0;
      for (int i = 1; i < 8; i++)
        if (wr_cyc_q[wb+i] - wr_cyc_q[wb+i-1] != 17) t++;
      chk_int("wr_spacing_bad", t, 0);
      chk_int("wr_to_done", done_cyc - wr_cyc_q[wb+7], 24);
    end
  endtask

  typedef struct {
    int gap;
    int lastp;
    bit rnd;
    int exp_wr;
    bit exp_done;
    bit exp_err;
    bit timing;
  } case_t;

  case_t tbl [5];

  initial begin
    int rb;
    int db;
    int t;
    tbl[0] = '{0,  127, 1'b0, 8, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{50, 127, 1'b0, 8, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{0,  40,  1'b0, 2, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{30, 127, 1'b0, 8, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{0,  -1,  1'b0, 8, 1'b1, 1'b1, 1'b1};

    sif.S_VALID = 1'b0;
    sif.S_DATA  = '0;
    sif.S_LAST  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    reset_chk();

    for (int c = 0; c < 5; c++)
      run_case(tbl[c].gap, tbl[c].lastp, tbl[c].rnd, tbl[c].exp_wr,
               tbl[c].exp_done, tbl[c].exp_err, tbl[c].timing);

    reset_chk();
    run_case(40, 127, 1'b1, 8, 1'b1, 1'b0, 1'b0);

    rb = run_total;
    for (int k = 0; k < 128; k++)
      send(16'(16'h0100 + k), k == 127, 0);
    t = 0;
    while (run_total - rb < 10 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk_int("run_timeout", t, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_int("mid_rst_rf_en", int'(rf_en), 0);
    chk_int("mid_rst_busy",  int'(busy), 0);
    chk_int("mid_rst_done",  int'(done), 0);
    chk_int("mid_rst_ready", int'(sif.S_READY), 1);
    db = done_total;
    repeat (40) @(negedge clk);
    chk_int("mid_rst_no_done", done_total - db, 0);

    run_case(0, 127, 1'b0, 8, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
